div_seq: RTL

Multi-cycle divide sequencer for the execute stage of the MIPS pipeline. It accepts a DIV/DIVU request from the ALU's decode of `alucontrol`, runs a 32-iteration restoring shift-subtract division, and produces the `{remainder, quotient}` word for HILO. It drives the execute-stage stall while busy and abandons work on an execute-stage flush. It replaces the single-cycle combinational `/` and `%` path.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 24 ++
 rtl/div_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } div_state_e;

  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS + 1);

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract iteration.
// dvd_next has a zero shifted in; the caller merges q_bit into bit 0.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next,
  output logic             q_bit
);

  logic [WIDTH:0]   rem_ext;
  logic [WIDTH-1:0] diff;

  assign rem_ext = {rem, dvd[WIDTH-1]};
  assign q_bit   = (rem_ext >= {1'b0, dvs});
  // When the subtract succeeds the true difference is below dvs, so the low bits suffice.
  assign diff     = rem_ext[WIDTH-1:0] - dvs;
  assign rem_next = q_bit ? diff : rem_ext[WIDTH-1:0];
  assign dvd_next = {dvd[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU with pipeline stall and flush.
// Optional macro DIV_ZERO_FASTPATH_EN: divide-by-zero skips the iteration phase.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               flush,
  output logic               stall_div,
  output logic               busy,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid
);

  localparam logic [DIV_CNT_W-1:0] LAST_ITER = DIV_CNT_W'(WIDTH - 1);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 sign_q, sign_d;
  logic                 quo_neg_q, quo_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;
  logic             step_q;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem_q),
    .dvd      (dvd_q),
    .dvs      (dvs_q),
    .rem_next (step_rem),
    .dvd_next (step_dvd),
    .q_bit    (step_q)
  );

  assign dvd_abs = (sign_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
  assign dvs_abs = (sign_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    sign_d    = sign_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          dvd_d   = opa;
          dvs_d   = opb;
          sign_d  = sign;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        dvd_d     = dvd_abs;
        dvs_d     = dvs_abs;
        quo_neg_d = sign_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
        rem_neg_d = sign_q & dvd_q[WIDTH-1];
        rem_d     = '0;
        cnt_d     = '0;
        state_d   = ST_RUN;
`ifdef DIV_ZERO_FASTPATH_EN
        // Preload exactly what 32 iterations against a zero divisor would leave behind.
        if (dvs_q == '0) begin
          rem_d   = dvd_abs;
          dvd_d   = '1;
          state_d = ST_FIX;
        end
`endif
      end
      ST_RUN: begin
        rem_d = step_rem;
        dvd_d = step_dvd | {{(WIDTH-1){1'b0}}, step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d = {(rem_neg_q ? -rem_q : rem_q), (quo_neg_q ? -dvd_q : dvd_q)};
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush abandons the operation and must never disturb the last result.
    if (flush && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      sign_q    <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      sign_q    <= sign_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
    end
  end

  // Low in DONE so EX/MEM can capture the result.
  assign stall_div    = ~flush & (((state_q == ST_IDLE) & start) |
                                  (state_q inside {ST_PREP, ST_RUN, ST_FIX}));
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign result       = result_q;

endmodule
